// File: rtl/cnn_layer_sequencer.sv
// Descriptor-driven CNN layer sequencer: walks a host-loaded layer table, issuing one engine command per tile.
// Command fields are held stable while eng_ready is low; a register read returns its data one cycle after the address.
module cnn_layer_sequencer #(
  parameter int MAX_LAYERS = 16,
  parameter int TILE_W     = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic [7:0]        cfg_raddr,
  output logic [31:0]       cfg_rdata,
  output logic              eng_start,
  input  logic              eng_ready,
  output logic [1:0]        eng_layer_type,
  output logic [ADDR_W-1:0] eng_weight_addr,
  output logic [TILE_W-1:0] eng_tile_idx,
  output logic              eng_buf_sel,
  input  logic              eng_tile_done,
  output logic              busy,
  output logic              done_irq
);

  localparam int          IW    = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
  localparam logic [31:0] MAX_L = MAX_LAYERS;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_NEXT, S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        desc_type  [MAX_LAYERS];
  logic [TILE_W-1:0] desc_tiles [MAX_LAYERS];
  logic [ADDR_W-1:0] desc_off   [MAX_LAYERS];

  logic [31:0]       num_layers;
  logic [ADDR_W-1:0] weight_base;
  logic [IW-1:0]     layer_idx;
  logic [TILE_W-1:0] tile_idx, cur_tiles;
  logic [1:0]        cur_type;
  logic [ADDR_W-1:0] cur_addr;
  logic              buf_sel, skip, done_f, err_f, abort_f;

  logic ctrl_wr, start_req, abort_req, cfg_ok, bad_cnt;
  logic w_hit, r_hit, tile_last, layer_last;
  logic [IW-1:0] w_idx, r_idx;
  logic [31:0] status, rd_nxt;

  assign ctrl_wr   = cfg_we && (cfg_addr == 8'h00);
  assign abort_req = ctrl_wr && cfg_wdata[1];
  assign start_req = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
  assign cfg_ok    = cfg_we && (state == S_IDLE);
  assign bad_cnt   = (num_layers == 32'd0) || (num_layers > MAX_L);

  // Descriptor window: 0x80 + 8*i, word select on bit 2, entries beyond the table ignored.
  assign w_hit = cfg_addr[7] && (cfg_addr[1:0] == 2'b00) && ({28'd0, cfg_addr[6:3]} < MAX_L);
  assign r_hit = cfg_raddr[7] && (cfg_raddr[1:0] == 2'b00) && ({28'd0, cfg_raddr[6:3]} < MAX_L);
  assign w_idx = IW'(cfg_addr[6:3]);
  assign r_idx = IW'(cfg_raddr[6:3]);

  assign tile_last  = ({1'b0, tile_idx} + (TILE_W+1)'(1)) >= {1'b0, cur_tiles};
  assign layer_last = (32'(layer_idx) + 32'd1) >= num_layers;

  assign status = {16'(tile_idx), 8'(layer_idx), {1'b0, state}, abort_f, err_f, done_f, busy};

  assign eng_layer_type  = cur_type;
  assign eng_weight_addr = cur_addr;
  assign eng_tile_idx    = tile_idx;
  assign eng_buf_sel     = buf_sel;

  always_comb begin
    state_nxt = state;
    eng_start = 1'b0;
    busy      = (state != S_IDLE);
    done_irq  = 1'b0;
    case (state)
      S_IDLE:   if (start_req && !bad_cnt) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = (desc_tiles[layer_idx] == '0) ? S_NEXT : S_ISSUE;
      S_ISSUE: begin
        eng_start = 1'b1;
        if (eng_ready) state_nxt = S_WAIT;
      end
      S_WAIT:   if (eng_tile_done) state_nxt = S_NEXT;
      S_NEXT: begin
        if (!skip && !tile_last) state_nxt = S_ISSUE;
        else if (layer_last)     state_nxt = S_FINISH;
        else                     state_nxt = S_FETCH;
      end
      S_FINISH: begin
        done_irq  = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
    // Abort overrides any handshake or completion seen in the same cycle.
    if (abort_req && state != S_IDLE) state_nxt = S_IDLE;
  end

  always_comb begin
    rd_nxt = 32'd0;
    case (cfg_raddr)
      8'h04:   rd_nxt = num_layers;
      8'h08:   rd_nxt = status;
      8'h0C:   rd_nxt = 32'(weight_base);
      default: begin
        if (r_hit) begin
          if (cfg_raddr[2]) rd_nxt = 32'(desc_off[r_idx]);
          else              rd_nxt = {desc_type[r_idx], {(30-TILE_W){1'b0}}, desc_tiles[r_idx]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && cfg_ok && w_hit) begin
      if (cfg_addr[2]) begin
        desc_off[w_idx] <= cfg_wdata[ADDR_W-1:0];
      end else begin
        desc_type[w_idx]  <= cfg_wdata[31:30];
        desc_tiles[w_idx] <= cfg_wdata[TILE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      num_layers  <= 32'd0;
      weight_base <= '0;
      layer_idx   <= '0;
      tile_idx    <= '0;
      cur_tiles   <= '0;
      cur_type    <= 2'd0;
      cur_addr    <= '0;
      buf_sel     <= 1'b0;
      skip        <= 1'b0;
      done_f      <= 1'b0;
      err_f       <= 1'b0;
      abort_f     <= 1'b0;
      cfg_rdata   <= 32'd0;
    end else begin
      state     <= state_nxt;
      cfg_rdata <= rd_nxt;
      if (cfg_ok && cfg_addr == 8'h04) num_layers  <= cfg_wdata;
      if (cfg_ok && cfg_addr == 8'h0C) weight_base <= cfg_wdata[ADDR_W-1:0];
      if (state == S_IDLE && start_req) begin
        if (bad_cnt) begin
          err_f <= 1'b1;
        end else begin
          done_f    <= 1'b0;
          err_f     <= 1'b0;
          abort_f   <= 1'b0;
          layer_idx <= '0;
          buf_sel   <= 1'b0;
        end
      end
      if (abort_req && state != S_IDLE) begin
        abort_f <= 1'b1;
      end else begin
        case (state)
          S_FETCH: begin
            cur_type  <= desc_type[layer_idx];
            cur_tiles <= desc_tiles[layer_idx];
            cur_addr  <= weight_base + desc_off[layer_idx];
            tile_idx  <= '0;
            skip      <= (desc_tiles[layer_idx] == '0);
          end
          S_NEXT: begin
            if (!skip && !tile_last) begin
              tile_idx <= tile_idx + TILE_W'(1);
            end else begin
              // Only a layer that actually ran flips the ping-pong buffers.
              if (!skip) buf_sel <= ~buf_sel;
              if (!layer_last) layer_idx <= layer_idx + IW'(1);
            end
          end
          S_FINISH: done_f <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: expected engine commands queued at start, checked at each handshake.
module tb_cnn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [7:0]  cfg_raddr;
  logic [31:0] cfg_rdata;
  logic        eng_start;
  logic        eng_ready;
  logic [1:0]  eng_layer_type;
  logic [31:0] eng_weight_addr;
  logic [15:0] eng_tile_idx;
  logic        eng_buf_sel;
  logic        eng_tile_done;
  logic        busy;
  logic        done_irq;

  logic auto_en    = 1'b0;
  logic auto_pulse = 1'b0;
  logic man_done   = 1'b0;
  int   pend       = 0;

  assign eng_tile_done = auto_pulse | man_done;

  cnn_layer_sequencer #(.MAX_LAYERS(16), .TILE_W(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_raddr(cfg_raddr), .cfg_rdata(cfg_rdata),
    .eng_start(eng_start), .eng_ready(eng_ready),
    .eng_layer_type(eng_layer_type), .eng_weight_addr(eng_weight_addr),
    .eng_tile_idx(eng_tile_idx), .eng_buf_sel(eng_buf_sel),
    .eng_tile_done(eng_tile_done), .busy(busy), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [15:0] tile;
    logic        bsel;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_issued = 0;
  int   irq_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [1:0] t, input logic [31:0] a, input logic [15:0] ti, input logic b);
    cmd_t c;
    c.typ = t; c.addr = a; c.tile = ti; c.bsel = b;
    return c;
  endfunction

  // Engine model and scoreboard: sampled on the falling edge, a handshake completes on the next rising edge.
  always @(negedge clk) begin
    cmd_t e;
    auto_pulse = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) auto_pulse = 1'b1;
    end
    if (!rst) begin
      if (done_irq) irq_cnt++;
      if (eng_start && eng_ready) begin
        n_issued++;
        chk("cmd_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("cmd_type", eng_layer_type, e.typ);
          chk("cmd_addr", eng_weight_addr, e.addr);
          chk("cmd_tile", eng_tile_idx, e.tile);
          chk("cmd_buf", eng_buf_sel, e.bsel);
        end
        if (auto_en) pend = 3;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    cfg_raddr = a;
    tick();
    d = cfg_rdata;
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && busy; i++) tick();
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_start(input int lim);
    for (int i = 0; i < lim && !eng_start; i++) tick();
    chk("start_seen", eng_start, 1'b1);
  endtask

  initial begin
    logic [31:0] r;
    int          iss0, irq0;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 8'h0; cfg_wdata = 32'h0;
    cfg_raddr = 8'h0; eng_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_outputs", {eng_start, busy, done_irq, eng_buf_sel, eng_layer_type}, 6'd0);
    chk("rst_addr", eng_weight_addr, 32'd0);
    rd(8'h08, r); chk("rst_status", r, 32'd0);
    rd(8'h04, r); chk("rst_num_layers", r, 32'd0);
    rd(8'h0C, r); chk("rst_weight_base", r, 32'd0);

    // Three layers, the middle one empty
    wr(8'h80, 32'h0000_0002); wr(8'h84, 32'h100);
    wr(8'h88, 32'h4000_0000); wr(8'h8C, 32'h0);
    wr(8'h90, 32'hC000_0001); wr(8'h94, 32'h200);
    wr(8'h0C, 32'h1000);      wr(8'h04, 32'd3);
    rd(8'h80, r); chk("desc0_w0_rb", r, 32'h0000_0002);
    rd(8'h90, r); chk("desc2_w0_rb", r, 32'hC000_0001);
    rd(8'h04, r); chk("num_layers_rb", r, 32'd3);
    exp_q.push_back(mk(2'd0, 32'h1100, 16'd0, 1'b0));
    exp_q.push_back(mk(2'd0, 32'h1100, 16'd1, 1'b0));
    exp_q.push_back(mk(2'd3, 32'h1200, 16'd0, 1'b1));
    eng_ready = 1'b1; auto_en = 1'b1;
    wr(8'h00, 32'h1);
    chk("fetch_cycle", {busy, eng_start}, 2'b10);
    tick();
    chk("issue_cycle", eng_start, 1'b1);
    wait_idle(300);
    chk("run1_queue_drained", exp_q.size(), 0);
    chk("run1_cmds", n_issued, 3);
    chk("run1_irq", irq_cnt, 1);
    chk("run1_final_buf", eng_buf_sel, 1'b0);
    rd(8'h08, r); chk("run1_status_flags", r[3:0], 4'b0010);

    // Zero layers
    iss0 = n_issued;
    wr(8'h04, 32'd0); wr(8'h00, 32'h1);
    chk("zero_busy", busy, 1'b0);
    repeat (3) tick();
    rd(8'h08, r); chk("zero_err", {r[2], r[0]}, 2'b10);
    chk("zero_no_cmd", n_issued, iss0);

    // Stall: ready low for five ISSUE cycles
    wr(8'h80, 32'h4000_0001); wr(8'h84, 32'h40); wr(8'h04, 32'd1);
    eng_ready = 1'b0;
    iss0 = n_issued; irq0 = irq_cnt;
    exp_q.push_back(mk(2'd1, 32'h1040, 16'd0, 1'b0));
    wr(8'h00, 32'h1);
    wait_start(20);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) eng_ready = 1'b1;
      chk("stall_hold", {eng_start, eng_layer_type, eng_weight_addr, eng_tile_idx, eng_buf_sel},
          {1'b1, 2'd1, 32'h1040, 16'd0, 1'b0});
      tick();
    end
    chk("stall_start_drop", eng_start, 1'b0);
    wait_idle(100);
    chk("stall_one_cmd", n_issued, iss0 + 1);
    chk("stall_irq", irq_cnt, irq0 + 1);
    rd(8'h08, r); chk("stall_err_cleared", r[2], 1'b0);

    // Too many layers
    iss0 = n_issued;
    wr(8'h04, 32'd17); wr(8'h00, 32'h1);
    repeat (3) tick();
    chk("over_busy", busy, 1'b0);
    rd(8'h08, r); chk("over_err", {r[2], r[0]}, 2'b10);
    chk("over_no_cmd", n_issued, iss0);

    // Abort in WAIT with tile_done the same cycle
    wr(8'h80, 32'h0000_0002); wr(8'h84, 32'h100); wr(8'h04, 32'd1);
    auto_en = 1'b0; pend = 0; eng_ready = 1'b1; irq0 = irq_cnt;
    exp_q.push_back(mk(2'd0, 32'h1100, 16'd0, 1'b0));
    wr(8'h00, 32'h1);
    wait_start(20);
    tick();
    chk("abort_in_wait", {busy, eng_start}, 2'b10);
    man_done = 1'b1;
    wr(8'h00, 32'h2);
    man_done = 1'b0;
    chk("abort_idle", {busy, eng_start}, 2'b00);
    repeat (4) tick();
    chk("abort_no_irq", irq_cnt, irq0);
    rd(8'h08, r); chk("abort_status", r[3:0], 4'b1000);

    // Config writes and restart while busy
    auto_en = 1'b1; eng_ready = 1'b0; irq0 = irq_cnt;
    exp_q.push_back(mk(2'd0, 32'h1100, 16'd0, 1'b0));
    exp_q.push_back(mk(2'd0, 32'h1100, 16'd1, 1'b0));
    wr(8'h00, 32'h1);
    wait_start(20);
    wr(8'h04, 32'd5); wr(8'h84, 32'h999); wr(8'h0C, 32'h2000);
    wr(8'h80, 32'h4000_0007); wr(8'h00, 32'h1);
    rd(8'h04, r); chk("busy_num_rb", r, 32'd1);
    rd(8'h84, r); chk("busy_desc_w1_rb", r, 32'h100);
    rd(8'h80, r); chk("busy_desc_w0_rb", r, 32'h2);
    rd(8'h0C, r); chk("busy_base_rb", r, 32'h1000);
    chk("busy_still_issue", eng_start, 1'b1);
    eng_ready = 1'b1;
    wait_idle(200);
    chk("busy_irq", irq_cnt, irq0 + 1);
    chk("busy_queue_drained", exp_q.size(), 0);

    // Reset in the middle of ISSUE, then a clean run
    eng_ready = 1'b0;
    wr(8'h00, 32'h1);
    wait_start(20);
    rst = 1'b1;
    tick();
    chk("midrst_outputs", {eng_start, busy, done_irq, eng_buf_sel, eng_layer_type, eng_tile_idx}, 22'd0);
    chk("midrst_addr", eng_weight_addr, 32'd0);
    rst = 1'b0;
    eng_ready = 1'b1; irq0 = irq_cnt;
    wr(8'h80, 32'h8000_0001); wr(8'h84, 32'h10);
    wr(8'h0C, 32'h3000);      wr(8'h04, 32'd1);
    exp_q.push_back(mk(2'd2, 32'h3010, 16'd0, 1'b0));
    wr(8'h00, 32'h1);
    wait_idle(100);
    chk("post_rst_irq", irq_cnt, irq0 + 1);
    chk("post_rst_buf", eng_buf_sel, 1'b1);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
